// File: rtl/sprite_pkg.sv
// Shared types and widths for the double-buffered sprite list scanner.
package sprite_pkg;

   localparam int unsigned CANVAS_WIDTH  = 100;
   localparam int unsigned CANVAS_HEIGHT = 100;
   localparam int unsigned NUM_FRAMES    = 100;
   localparam int unsigned MAX_SPRITES   = 16;

   localparam int unsigned X_W   = $clog2(CANVAS_WIDTH);
   localparam int unsigned Y_W   = $clog2(CANVAS_HEIGHT);
   localparam int unsigned F_W   = $clog2(NUM_FRAMES);
   localparam int unsigned IDX_W = $clog2(MAX_SPRITES);
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [F_W-1:0] frame;
   } sprite_rec_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   // True when every field of a record lies inside its legal range.
   function automatic logic rec_in_range(input sprite_rec_t r);
      return (r.x < X_W'(CANVAS_WIDTH)) && (r.y < Y_W'(CANVAS_HEIGHT)) &&
             (r.frame < F_W'(NUM_FRAMES));
   endfunction

endpackage

// File: rtl/sprite_bank.sv
// One sprite bank: record storage, active vector, one write port,
// combinational read port and synchronous clear of all active bits.
module sprite_bank
   import sprite_pkg::*;
(
   input  logic             clk,
   input  logic             i_clear_all,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  sprite_rec_t      i_wr_rec,
   input  logic [IDX_W-1:0] i_rd_idx,
   output sprite_rec_t      o_rd_rec_c,
   output logic             o_rd_active_c
);

   sprite_rec_t            r_mem [MAX_SPRITES];
   logic [MAX_SPRITES-1:0] r_active;

   // Clear wins over a same-cycle write so a freshly swapped-in bank starts empty.
   always_ff @(posedge clk) begin
      if (i_clear_all) begin
         r_active <= '0;
      end else if (i_we) begin
         r_active[i_wr_idx] <= 1'b1;
      end
      if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_rec;
      end
   end

   assign o_rd_rec_c    = r_mem[i_rd_idx];
   assign o_rd_active_c = r_active[i_rd_idx];

endmodule

// File: rtl/sprite_list_scanner.sv
// Double-buffered sprite table: swaps banks on new_frame and streams the
// previous write bank out one active record per valid/ready handshake.
module sprite_list_scanner
   import sprite_pkg::*;
(
   input  logic             pixel_clk_in,
   input  logic             rst_in,
   input  logic             new_frame,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [X_W-1:0]   wr_x,
   input  logic [Y_W-1:0]   wr_y,
   input  logic [F_W-1:0]   wr_frame,
   output logic             wr_err,
   output logic             sprite_valid,
   input  logic             sprite_ready,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [F_W-1:0]   frame,
   output logic [IDX_W-1:0] sprite_idx,
   output logic             frame_done,
   output logic             busy,
   output logic             overrun
);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt;
   logic             r_bank_sel, w_bank_sel_nxt;
   logic             r_valid, w_valid_nxt;
   sprite_rec_t      r_rec, w_rec_nxt;
   logic [IDX_W-1:0] r_sprite_idx, w_sprite_idx_nxt;
   logic             r_frame_done, w_frame_done_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_overrun, w_overrun_nxt;
   logic             r_wr_err;

   logic             w_swap, w_out_free, w_wr_ok, w_rd_sel;
   sprite_rec_t      w_wr_rec;
   sprite_rec_t      w_rd_rec [2];
   logic [1:0]       w_rd_active, w_bank_we, w_bank_clr;

   assign w_wr_rec = '{x: wr_x, y: wr_y, frame: wr_frame};
   assign w_wr_ok  = wr_en && rec_in_range(w_wr_rec) &&
                     (CNT_W'(wr_idx) < CNT_W'(MAX_SPRITES));
   assign w_swap   = (r_state == ST_IDLE) && new_frame;
   assign w_rd_sel = ~r_bank_sel;

   // bank_sel names the write bank; the other one is scanned and is cleared on swap.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign w_bank_we[b]  = w_wr_ok && !rst_in && (r_bank_sel == 1'(b));
      assign w_bank_clr[b] = rst_in || (w_swap && (r_bank_sel != 1'(b)));

      sprite_bank u_bank (
         .clk           (pixel_clk_in),
         .i_clear_all   (w_bank_clr[b]),
         .i_we          (w_bank_we[b]),
         .i_wr_idx      (wr_idx),
         .i_wr_rec      (w_wr_rec),
         .i_rd_idx      (r_idx[IDX_W-1:0]),
         .o_rd_rec_c    (w_rd_rec[b]),
         .o_rd_active_c (w_rd_active[b])
      );
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_bank_sel_nxt   = r_bank_sel;
      w_valid_nxt      = r_valid;
      w_rec_nxt        = r_rec;
      w_sprite_idx_nxt = r_sprite_idx;
      w_frame_done_nxt = 1'b0;
      w_busy_nxt       = r_busy;
      w_overrun_nxt    = r_overrun;
      w_out_free       = !r_valid || sprite_ready;

      case (r_state)
         ST_IDLE: begin
            if (new_frame) begin
               w_state_nxt    = ST_SCAN;
               w_bank_sel_nxt = ~r_bank_sel;
               w_idx_nxt      = '0;
               w_busy_nxt     = 1'b1;
            end
         end
         ST_SCAN: begin
            if (new_frame) begin
               w_overrun_nxt = 1'b1;
            end
            // The index advances as a record is loaded, so a consume and the next lookup overlap.
            if (w_out_free) begin
               w_valid_nxt = 1'b0;
               if (r_idx == CNT_W'(MAX_SPRITES)) begin
                  w_state_nxt      = ST_DONE;
                  w_frame_done_nxt = 1'b1;
                  w_busy_nxt       = 1'b0;
               end else if (w_rd_active[w_rd_sel]) begin
                  w_valid_nxt      = 1'b1;
                  w_rec_nxt        = w_rd_rec[w_rd_sel];
                  w_sprite_idx_nxt = r_idx[IDX_W-1:0];
                  w_idx_nxt        = r_idx + CNT_W'(1);
               end else begin
                  w_idx_nxt = r_idx + CNT_W'(1);
                  if (r_idx == CNT_W'(MAX_SPRITES - 1)) begin
                     w_state_nxt      = ST_DONE;
                     w_frame_done_nxt = 1'b1;
                     w_busy_nxt       = 1'b0;
                  end
               end
            end
         end
         ST_DONE: begin
            if (new_frame) begin
               w_overrun_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_bank_sel   <= 1'b0;
         r_valid      <= 1'b0;
         r_rec        <= '0;
         r_sprite_idx <= '0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         r_wr_err     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_bank_sel   <= w_bank_sel_nxt;
         r_valid      <= w_valid_nxt;
         r_rec        <= w_rec_nxt;
         r_sprite_idx <= w_sprite_idx_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_busy       <= w_busy_nxt;
         r_overrun    <= w_overrun_nxt;
         r_wr_err     <= wr_en && !w_wr_ok;
      end
   end

   assign wr_err       = r_wr_err;
   assign sprite_valid = r_valid;
   assign x            = r_rec.x;
   assign y            = r_rec.y;
   assign frame        = r_rec.frame;
   assign sprite_idx   = r_sprite_idx;
   assign frame_done   = r_frame_done;
   assign busy         = r_busy;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_sprite_list_scanner.sv
// Scoreboard bench for sprite_list_scanner: stimulus queues expected records
// and frame_done cycles, a negedge monitor pops and compares them.
module tb_sprite_list_scanner;
   import sprite_pkg::*;

   logic             clk = 1'b0;
   logic             rst_in = 1'b1;
   logic             new_frame = 1'b0;
   logic             wr_en = 1'b0;
   logic [IDX_W-1:0] wr_idx = '0;
   logic [X_W-1:0]   wr_x = '0;
   logic [Y_W-1:0]   wr_y = '0;
   logic [F_W-1:0]   wr_frame = '0;
   logic             sprite_ready = 1'b1;
   logic             wr_err, sprite_valid, frame_done, busy, overrun;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [F_W-1:0]   frame;
   logic [IDX_W-1:0] sprite_idx;

   typedef struct {
      int idx;
      int x;
      int y;
      int f;
   } exp_t;

   exp_t exp_q[$];
   int   exp_done[$];
   int   n_checks = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   hold_cnt = 0;
   int   err_cnt = 0;
   int   done_cnt = 0;
   int   watch_first = 0;
   int   exp_first = 0;
   int   frame_n = 0;

   sprite_list_scanner dut (
      .pixel_clk_in (clk),
      .rst_in       (rst_in),
      .new_frame    (new_frame),
      .wr_en        (wr_en),
      .wr_idx       (wr_idx),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_frame     (wr_frame),
      .wr_err       (wr_err),
      .sprite_valid (sprite_valid),
      .sprite_ready (sprite_ready),
      .x            (x),
      .y            (y),
      .frame        (frame),
      .sprite_idx   (sprite_idx),
      .frame_done   (frame_done),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares the presented record against the queue head every valid cycle.
   initial forever begin
      @(negedge clk);
      if (!rst_in) begin
         if (sprite_valid) begin
            if (watch_first != 0) begin
               check("first_valid_cycle", cyc, exp_first);
               watch_first = 0;
            end
            if (exp_q.size() == 0) begin
               n_checks++;
               n_bad++;
               $display("FAIL unexpected_record: got idx %0d expected none", sprite_idx);
            end else begin
               check("record", {sprite_idx, x, y, frame},
                     {4'(exp_q[0].idx), 7'(exp_q[0].x), 7'(exp_q[0].y), 7'(exp_q[0].f)});
               if (sprite_ready) void'(exp_q.pop_front());
            end
            if (!sprite_ready) hold_cnt++;
         end
         if (wr_err) err_cnt++;
         if (frame_done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
            check("records_left_at_done", exp_q.size(), 0);
            if (exp_done.size() == 0) begin
               n_checks++;
               n_bad++;
               $display("FAIL unexpected_frame_done: got pulse expected none (cycle %0d)", cyc);
            end else begin
               int e;
               e = exp_done.pop_front();
               if (e >= 0) check("frame_done_cycle", cyc, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_rec(input int idx, input int wx, input int wy, input int wf);
      wr_en = 1'b1; wr_idx = 4'(idx); wr_x = 7'(wx); wr_y = 7'(wy); wr_frame = 7'(wf);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic expect_rec(input int idx, input int ex, input int ey, input int ef);
      exp_t e;
      e.idx = idx; e.x = ex; e.y = ey; e.f = ef;
      exp_q.push_back(e);
   endtask

   task automatic start_frame(input bit timed_done, input bit timed_first);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      frame_n = cyc;
      exp_done.push_back(timed_done ? frame_n + int'(MAX_SPRITES) : -1);
      if (timed_first) begin
         exp_first = frame_n + 1;
         watch_first = 1;
      end
      check("busy_after_swap", busy, 1);
   endtask

   task automatic wait_done(input string name);
      int start;
      bit seen;
      start = done_cnt;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (done_cnt != start) seen = 1;
      end
      if (!seen) begin
         n_checks++;
         n_bad++;
         $display("FAIL %s_timeout: got no frame_done expected one within 200 cycles", name);
      end
      tick();
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (sprite_valid) seen = 1;
      end
      if (!seen) begin
         n_checks++;
         n_bad++;
         $display("FAIL %s_timeout: got no sprite_valid expected one within 100 cycles", name);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      repeat (3) tick();
      rst_in = 1'b0;
      check("reset_outputs", {wr_err, sprite_valid, x, y, frame, sprite_idx, frame_done, busy, overrun}, 0);

      // 1: two slots, ready held high, exact latencies
      write_rec(0, 10, 20, 3);
      write_rec(5, 99, 99, 99);
      expect_rec(0, 10, 20, 3);
      expect_rec(5, 99, 99, 99);
      start_frame(1, 1);
      wait_done("t1");

      // 2: backpressure on first record for 7 cycles, adjacent slots both emitted
      write_rec(1, 11, 12, 13);
      write_rec(2, 21, 22, 23);
      expect_rec(1, 11, 12, 13);
      expect_rec(2, 21, 22, 23);
      sprite_ready = 1'b0;
      hold_cnt = 0;
      start_frame(0, 0);
      wait_valid("t2");
      repeat (7) tick();
      sprite_ready = 1'b1;
      wait_done("t2");
      check("hold_cycles", hold_cnt, 7);

      // 3: out-of-range writes are dropped with a wr_err pulse each
      e0 = err_cnt;
      write_rec(4, 100, 1, 1);
      tick();
      write_rec(6, 1, 100, 1);
      tick();
      write_rec(8, 1, 1, 127);
      tick();
      check("wr_err_pulses", err_cnt - e0, 3);
      check("wr_err_low_after", wr_err, 0);

      // 4: write coinciding with swap lands in the scanned bank; dropped writes stay inactive
      wr_en = 1'b1; wr_idx = 4'd2; wr_x = 7'd7; wr_y = 7'd8; wr_frame = 7'd9;
      expect_rec(2, 7, 8, 9);
      start_frame(0, 0);
      wr_en = 1'b0;
      wait_done("t4a");
      start_frame(1, 0);
      wait_done("t4b");

      // 5: new_frame during scan sets overrun but does not swap
      write_rec(3, 1, 2, 3);
      expect_rec(3, 1, 2, 3);
      sprite_ready = 1'b0;
      start_frame(0, 0);
      wait_valid("t5");
      check("overrun_before", overrun, 0);
      write_rec(7, 70, 71, 72);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      check("overrun_set", overrun, 1);
      check("busy_during_overrun", busy, 1);
      sprite_ready = 1'b1;
      wait_done("t5a");
      check("overrun_sticky", overrun, 1);
      expect_rec(7, 70, 71, 72);
      start_frame(0, 0);
      wait_done("t5b");

      // 6: reset while a record is presented
      write_rec(0, 50, 51, 52);
      expect_rec(0, 50, 51, 52);
      sprite_ready = 1'b0;
      start_frame(0, 0);
      wait_valid("t6");
      rst_in = 1'b1;
      exp_q.delete();
      exp_done.delete();
      tick();
      rst_in = 1'b0;
      check("midscan_reset_outputs", {wr_err, sprite_valid, x, y, frame, sprite_idx, frame_done, busy, overrun}, 0);
      sprite_ready = 1'b1;
      repeat (20) tick();
      start_frame(1, 0);
      wait_done("t6");

      repeat (3) tick();
      check("records_left_end", exp_q.size(), 0);
      check("done_left_end", exp_done.size(), 0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
